// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_W   = 8;
  localparam int unsigned UART_RX_DEPTH = 512;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DRAIN
  } uart_rx_ring_state_t;

endpackage

// File: rtl/uart_ring_ptr.sv
// Ring bookkeeping: write/read pointers, fill level, overflow and threshold flags.
module uart_ring_ptr
  import uart_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_inc_i,
  input  logic              drop_i,
  input  logic              rd_release_i,
  input  logic [ADDR_W:0]   rd_count_i,
  input  logic              flush_i,
  input  logic              ovf_clr_i,
  input  logic [ADDR_W:0]   thresh_i,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic [ADDR_W-1:0] rd_ptr_o,
  output logic [ADDR_W:0]   level_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic              thresh_hit_o
);

  localparam logic [ADDR_W:0] FullLevel = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d, level_inc, rel_cnt;
  logic              empty_q, empty_d, full_q, full_d;
  logic              ovf_q, ovf_d, thresh_hit_q, thresh_hit_d;

  always_comb begin
    // Apply the pending write first so a same-cycle release may free that word too.
    level_inc = level_q + {{ADDR_W{1'b0}}, wr_inc_i};
    rel_cnt   = '0;
    if (rd_release_i) begin
      rel_cnt = (rd_count_i < level_inc) ? rd_count_i : level_inc;
    end
    level_d      = level_inc - rel_cnt;
    wr_ptr_d     = wr_ptr_q + {{(ADDR_W-1){1'b0}}, wr_inc_i};
    rd_ptr_d     = rd_ptr_q + rel_cnt[ADDR_W-1:0];
    empty_d      = (level_d == '0);
    full_d       = (level_d == FullLevel);
    thresh_hit_d = (level_d >= thresh_i);
    ovf_d        = ovf_q;
    if (drop_i) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    if (flush_i) begin
      level_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      empty_d      = 1'b1;
      full_d       = 1'b0;
      thresh_hit_d = 1'b0;
      ovf_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      ovf_q        <= 1'b0;
      thresh_hit_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      ovf_q        <= ovf_d;
      thresh_hit_q <= thresh_hit_d;
    end
  end

  assign wr_ptr_o     = wr_ptr_q;
  assign rd_ptr_o     = rd_ptr_q;
  assign level_o      = level_q;
  assign empty_o      = empty_q;
  assign full_o       = full_q;
  assign overflow_o   = ovf_q;
  assign thresh_hit_o = thresh_hit_q;

endmodule

// File: rtl/uart_rx_ring.sv
// Accepts words from uart_rx and writes them into a circular Rx buffer RAM.
// DEPTH must be a power of two, at least 4.
module uart_rx_ring
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned DEPTH  = UART_RX_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_data_ready,
  output logic              rx_data_ack,
  output logic [DATA_W-1:0] mem_wd,
  output logic [ADDR_W-1:0] mem_wa,
  output logic              mem_wen,
  input  logic              rd_release,
  input  logic [ADDR_W:0]   rd_count,
  input  logic              flush,
  input  logic              ovf_clr,
  input  logic [ADDR_W:0]   thresh,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              thresh_hit
);

  uart_rx_ring_state_t state_q, state_d;
  logic [DATA_W-1:0]   mem_wd_q, mem_wd_d;
  logic [ADDR_W-1:0]   mem_wa_q, mem_wa_d;
  logic                mem_wen_q, mem_wen_d;
  logic                ack_q, ack_d;
  logic                wr_inc, drop;

  always_comb begin
    state_d   = state_q;
    mem_wd_d  = mem_wd_q;
    mem_wa_d  = mem_wa_q;
    mem_wen_d = 1'b0;
    ack_d     = 1'b0;
    wr_inc    = 1'b0;
    drop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_data_ready) begin
          ack_d = 1'b1;
          if (flush) begin
            // Handshake completes so uart_rx moves on; the word is discarded.
            state_d = DRAIN;
          end else if (full) begin
            drop    = 1'b1;
            state_d = DRAIN;
          end else begin
            mem_wd_d  = rx_data;
            mem_wa_d  = wr_ptr;
            mem_wen_d = 1'b1;
            state_d   = WRITE;
          end
        end
      end
      WRITE: begin
        wr_inc  = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (!rx_data_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      mem_wd_d  = '0;
      mem_wa_d  = '0;
      mem_wen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mem_wd_q  <= '0;
      mem_wa_q  <= '0;
      mem_wen_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_wd_q  <= mem_wd_d;
      mem_wa_q  <= mem_wa_d;
      mem_wen_q <= mem_wen_d;
      ack_q     <= ack_d;
    end
  end

  assign rx_data_ack = ack_q;
  assign mem_wd      = mem_wd_q;
  assign mem_wa      = mem_wa_q;
  assign mem_wen     = mem_wen_q;

  uart_ring_ptr #(
    .ADDR_W(ADDR_W)
  ) u_ptr (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_inc_i    (wr_inc),
    .drop_i      (drop),
    .rd_release_i(rd_release),
    .rd_count_i  (rd_count),
    .flush_i     (flush),
    .ovf_clr_i   (ovf_clr),
    .thresh_i    (thresh),
    .wr_ptr_o    (wr_ptr),
    .rd_ptr_o    (rd_ptr),
    .level_o     (level),
    .empty_o     (empty),
    .full_o      (full),
    .overflow_o  (overflow),
    .thresh_hit_o(thresh_hit)
  );

endmodule
